// File: rtl/n64adv2_vdemux_pkg.sv
// n64adv2_vdemux_pkg: shared widths, sync bit indices, thresholds, FSM states and pixel type
package n64adv2_vdemux_pkg;
  localparam int color_width_i = 7;
  localparam int vsync_idx = 3;
  localparam int clamp_idx = 2;
  localparam int hsync_idx = 1;
  localparam int csync_idx = 0;
  localparam int pal_line_thresh = 288;
  localparam int line_cnt_width = 11;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_R = 2'd1, S_G = 2'd2, S_B = 2'd3} state_e;
  typedef struct packed {
    logic [3:0] sync;
    logic [color_width_i-1:0] r;
    logic [color_width_i-1:0] g;
    logic [color_width_i-1:0] b;
  } pixel_t;
endpackage

// File: rtl/n64adv2_vdemux_if.sv
// n64adv2_vdemux_if: muxed N64 video input bus plus demuxed pixel and mode outputs
interface n64adv2_vdemux_if;
  import n64adv2_vdemux_pkg::*;
  logic nVDSYNC_i;
  logic [color_width_i-1:0] VD_i;
  logic vdata_valid_o;
  logic [3:0] vdata_sync_o;
  logic [color_width_i-1:0] vdata_r_o;
  logic [color_width_i-1:0] vdata_g_o;
  logic [color_width_i-1:0] vdata_b_o;
  logic palmode_o;
  logic interlaced_o;
  logic field_o;
  logic pixel_error_o;
  modport master (
    output nVDSYNC_i, VD_i,
    input vdata_valid_o, vdata_sync_o, vdata_r_o, vdata_g_o, vdata_b_o,
    input palmode_o, interlaced_o, field_o, pixel_error_o
  );
  modport slave (
    input nVDSYNC_i, VD_i,
    output vdata_valid_o, vdata_sync_o, vdata_r_o, vdata_g_o, vdata_b_o,
    output palmode_o, interlaced_o, field_o, pixel_error_o
  );
endinterface

// File: rtl/n64adv2_vinfo_detect.sv
// n64adv2_vinfo_detect: line counting and PAL/field/interlace detection from strobed sync bits
module n64adv2_vinfo_detect
  import n64adv2_vdemux_pkg::*;
#(
  parameter int pal_thresh = pal_line_thresh,
  parameter int cnt_width = line_cnt_width
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  input  logic vsync_i,
  input  logic hsync_i,
  output logic palmode_o,
  output logic interlaced_o,
  output logic field_o
);
  localparam logic [cnt_width-1:0] thresh = cnt_width'(pal_thresh);
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic vs_prev_q, vs_prev_d, hs_prev_q, hs_prev_d;
  logic pal_q, pal_d, intl_q, intl_d, field_q, field_d, seen_q, seen_d;
  // edge detection on strobed sync; a VSYNC fall wins over a simultaneous HSYNC fall
  always_comb begin
    cnt_d = cnt_q;
    vs_prev_d = vs_prev_q;
    hs_prev_d = hs_prev_q;
    pal_d = pal_q;
    intl_d = intl_q;
    field_d = field_q;
    seen_d = seen_q;
    if (strobe_i) begin
      vs_prev_d = vsync_i;
      hs_prev_d = hsync_i;
      if (vs_prev_q && !vsync_i) begin
        pal_d = cnt_q > thresh;
        field_d = hsync_i;
        intl_d = seen_q && (hsync_i != field_q);
        seen_d = 1'b1;
        cnt_d = '0;
      end else if (hs_prev_q && !hsync_i && cnt_q != '1) begin
        cnt_d = cnt_q + cnt_width'(1);
      end
    end
  end
  // mode state registers; previous sync starts inactive (high) like the output word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      vs_prev_q <= 1'b1;
      hs_prev_q <= 1'b1;
      pal_q <= 1'b0;
      intl_q <= 1'b0;
      field_q <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      vs_prev_q <= vs_prev_d;
      hs_prev_q <= hs_prev_d;
      pal_q <= pal_d;
      intl_q <= intl_d;
      field_q <= field_d;
      seen_q <= seen_d;
    end
  end
  assign palmode_o = pal_q;
  assign interlaced_o = intl_q;
  assign field_o = field_q;
endmodule

// File: rtl/n64adv2_vdemux.sv
// n64adv2_vdemux: demuxes the N64 sync/R/G/B video bus into parallel pixel words
module n64adv2_vdemux
  import n64adv2_vdemux_pkg::*;
(
  input logic N64_CLK_i,
  input logic N64_nVRST_i,
  n64adv2_vdemux_if.slave vif
);
  state_e state_q, state_d;
  logic [3:0] sync_buf_q, sync_buf_d;
  logic [color_width_i-1:0] r_buf_q, r_buf_d, g_buf_q, g_buf_d;
  pixel_t pix_q, pix_d;
  logic valid_q, valid_d, err_q, err_d;
  // pixel sequencer: a sync word always restarts, a premature one flags an error
  always_comb begin
    state_d = state_q;
    sync_buf_d = sync_buf_q;
    r_buf_d = r_buf_q;
    g_buf_d = g_buf_q;
    pix_d = pix_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    if (!vif.nVDSYNC_i) begin
      sync_buf_d = vif.VD_i[3:0];
      state_d = S_R;
      err_d = state_q != S_IDLE;
    end else begin
      case (state_q)
        S_R: begin
          r_buf_d = vif.VD_i;
          state_d = S_G;
        end
        S_G: begin
          g_buf_d = vif.VD_i;
          state_d = S_B;
        end
        S_B: begin
          pix_d = '{sync: sync_buf_q, r: r_buf_q, g: g_buf_q, b: vif.VD_i};
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  // state, capture buffers and the atomically updated output word
  always_ff @(posedge N64_CLK_i or negedge N64_nVRST_i) begin
    if (!N64_nVRST_i) begin
      state_q <= S_IDLE;
      sync_buf_q <= 4'hF;
      r_buf_q <= '0;
      g_buf_q <= '0;
      pix_q <= '{sync: 4'hF, r: '0, g: '0, b: '0};
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_buf_q <= sync_buf_d;
      r_buf_q <= r_buf_d;
      g_buf_q <= g_buf_d;
      pix_q <= pix_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
  n64adv2_vinfo_detect u_vinfo (
    .clk(N64_CLK_i),
    .rst_n(N64_nVRST_i),
    .strobe_i(valid_q),
    .vsync_i(pix_q.sync[vsync_idx]),
    .hsync_i(pix_q.sync[hsync_idx]),
    .palmode_o(vif.palmode_o),
    .interlaced_o(vif.interlaced_o),
    .field_o(vif.field_o)
  );
  assign vif.vdata_valid_o = valid_q;
  assign vif.vdata_sync_o = pix_q.sync;
  assign vif.vdata_r_o = pix_q.r;
  assign vif.vdata_g_o = pix_q.g;
  assign vif.vdata_b_o = pix_q.b;
  assign vif.pixel_error_o = err_q;
endmodule

// File: tb/tb_n64adv2_vdemux.sv
// tb_n64adv2_vdemux: directed/randomized bench with a frame-level reference model
module tb_n64adv2_vdemux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passes = 0;
  logic [3:0] e_sync;
  logic [6:0] e_r, e_g, e_b;
  logic m_pal, m_field, m_intl, m_seen;
  int m_lines;

  n64adv2_vdemux_if vif ();
  n64adv2_vdemux dut (.N64_CLK_i(clk), .N64_nVRST_i(rst_n), .vif(vif));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic cyc(input logic nv, input logic [6:0] vd);
    vif.nVDSYNC_i = nv;
    vif.VD_i = vd;
    @(negedge clk);
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_sync"}, 32'(vif.vdata_sync_o), 32'(e_sync));
    chk({tag, "_rgb"}, {11'd0, vif.vdata_r_o, vif.vdata_g_o, vif.vdata_b_o}, {11'd0, e_r, e_g, e_b});
  endtask

  task automatic chk_mode(input string tag);
    chk({tag, "_pal"}, 32'(vif.palmode_o), 32'(m_pal));
    chk({tag, "_intl"}, 32'(vif.interlaced_o), 32'(m_intl));
    chk({tag, "_field"}, 32'(vif.field_o), 32'(m_field));
  endtask

  task automatic model_reset();
    e_sync = 4'hF; e_r = 0; e_g = 0; e_b = 0;
    m_pal = 0; m_field = 0; m_intl = 0; m_seen = 0; m_lines = 0;
  endtask

  task automatic send_pixel(input logic [3:0] s, input int gaps);
    logic [6:0] r, g, b;
    r = 7'($urandom_range(0, 127));
    g = 7'($urandom_range(0, 127));
    b = 7'($urandom_range(0, 127));
    cyc(1'b0, {3'($urandom_range(0, 7)), s});
    chk("sync_novalid", 32'(vif.vdata_valid_o), 0);
    chk("sync_noerr", 32'(vif.pixel_error_o), 0);
    cyc(1'b1, r);
    chk("r_novalid", 32'(vif.vdata_valid_o), 0);
    cyc(1'b1, g);
    chk("g_novalid", 32'(vif.vdata_valid_o), 0);
    chk_held("partial_held");
    cyc(1'b1, b);
    e_sync = s; e_r = r; e_g = g; e_b = b;
    chk("b_valid", 32'(vif.vdata_valid_o), 1);
    chk_held("pixel");
    for (int i = 0; i < gaps; i++) begin
      cyc(1'b1, 7'($urandom_range(0, 127)));
      chk("gap_novalid", 32'(vif.vdata_valid_o), 0);
      chk_held("gap_held");
    end
  endtask

  task automatic run_field(input logic f, input int n);
    chk_mode("pre_vs_stable");
    send_pixel({1'b0, 1'b1, f, 1'b1}, 0);
    m_pal = m_lines > 288;
    m_intl = m_seen && (f != m_field);
    m_field = f;
    m_seen = 1'b1;
    m_lines = 0;
    send_pixel(4'hF, 0);
    chk_mode("post_vs");
    for (int i = 0; i < n; i++) begin
      send_pixel(4'b1101, 0);
      send_pixel(4'hF, 0);
    end
    m_lines = n;
  endtask

  initial begin
    vif.nVDSYNC_i = 1'b1;
    vif.VD_i = '0;
    model_reset();
    #12;
    chk("rst_valid", 32'(vif.vdata_valid_o), 0);
    chk("rst_err", 32'(vif.pixel_error_o), 0);
    chk_held("rst");
    chk_mode("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    cyc(1'b0, 7'h0F);
    cyc(1'b1, 7'h11);
    cyc(1'b1, 7'h22);
    cyc(1'b1, 7'h33);
    chk("fixed_valid", 32'(vif.vdata_valid_o), 1);
    chk("fixed_pixel", {vif.vdata_sync_o, vif.vdata_r_o, vif.vdata_g_o, vif.vdata_b_o}, {4'hF, 7'h11, 7'h22, 7'h33});
    e_sync = 4'hF; e_r = 7'h11; e_g = 7'h22; e_b = 7'h33;
    for (int i = 0; i < 4; i++) send_pixel(4'hF, 0);
    for (int i = 0; i < 4; i++) send_pixel(4'hF, 4);

    cyc(1'b0, 7'h0F);
    cyc(1'b1, 7'h55);
    cyc(1'b0, 7'h0F);
    chk("err_pulse", 32'(vif.pixel_error_o), 1);
    chk("err_novalid", 32'(vif.vdata_valid_o), 0);
    chk_held("err_held");
    cyc(1'b1, 7'h21);
    chk("err_one_cycle", 32'(vif.pixel_error_o), 0);
    cyc(1'b1, 7'h42);
    chk("err_g_novalid", 32'(vif.vdata_valid_o), 0);
    cyc(1'b1, 7'h63);
    chk("after_err_valid", 32'(vif.vdata_valid_o), 1);
    chk("after_err_pixel", {vif.vdata_sync_o, vif.vdata_r_o, vif.vdata_g_o, vif.vdata_b_o}, {4'hF, 7'h21, 7'h42, 7'h63});
    e_sync = 4'hF; e_r = 7'h21; e_g = 7'h42; e_b = 7'h63;
    send_pixel(4'hF, 2);

    run_field(1'b0, 263);
    run_field(1'b0, 263);
    run_field(1'b0, 313);
    run_field(1'b1, 100);
    run_field(1'b0, 50);
    run_field(1'b1, 5);
    chk_mode("final_fields");

    cyc(1'b0, 7'h0F);
    cyc(1'b1, 7'h7F);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_valid", 32'(vif.vdata_valid_o), 0);
    chk("midrst_err", 32'(vif.pixel_error_o), 0);
    chk_held("midrst");
    chk_mode("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 7'h7F);
      chk("postrst_novalid", 32'(vif.vdata_valid_o), 0);
      chk_held("postrst_held");
    end
    send_pixel(4'hF, 1);
    run_field(1'b1, 10);
    run_field(1'b0, 0);
    run_field(1'b1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
